// File: rtl/i2c_fifo_pkg.sv
// Shared FIFO pointer helpers: default sizing, depth derivation and Gray/binary conversion.
// Functions operate on the widest legal pointer; narrower pointers are zero-extended.
package i2c_fifo_pkg;

   localparam int default_addr_size = 4;
   localparam int max_addr_size     = 8;
   localparam int ptr_w_max         = max_addr_size + 1;

   typedef logic [ptr_w_max-1:0] ptr_t;

   function automatic int fifo_depth(input int addr_size);
      return 1 << addr_size;
   endfunction

   function automatic ptr_t bin2gray(input ptr_t bin);
      return (bin >> 1) ^ bin;
   endfunction

   // Zero upper bits of a zero-extended Gray value leave the lower result unaffected
   function automatic ptr_t gray2bin(input ptr_t gray);
      ptr_t bin;
      bin[ptr_w_max-1] = gray[ptr_w_max-1];
      for (int i = ptr_w_max - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for Gray pointers crossing into this clock domain.
module sync_2ff #(
   parameter int width = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [width-1:0] din,
   output logic [width-1:0] dout
);

   logic [width-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         dout <= '0;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/write_full_block.sv
// Write-side pointer, full/almost-full, level and sticky overflow logic of an async FIFO.
// Memory lives outside; only the address and Gray pointer leave this block.
module write_full_block
   import i2c_fifo_pkg::*;
#(
   parameter int addr_size       = default_addr_size,
   parameter int almost_full_gap = 2
) (
   input  logic                 write_clock_i,
   input  logic                 write_reset_i,
   input  logic                 write_inc_i,
   input  logic [addr_size:0]   read_to_write_pointer_i,
   input  logic                 write_overflow_clear_i,
   output logic [addr_size-1:0] write_address_o,
   output logic [addr_size:0]   write_pointer_o,
   output logic                 write_full_o,
   output logic                 write_almost_full_o,
   output logic [addr_size:0]   write_level_o,
   output logic                 write_overflow_o
);

   localparam int ptr_w = addr_size + 1;
   localparam int depth = fifo_depth(addr_size);
   localparam logic [ptr_w-1:0] almost_threshold = ptr_w'(depth - almost_full_gap);

   logic [ptr_w-1:0] wbin;
   logic [ptr_w-1:0] wbin_next;
   logic [ptr_w-1:0] wgray_next;
   logic [ptr_w-1:0] rq2;
   logic [ptr_w-1:0] rbin_sync;
   logic [ptr_w-1:0] level_next;
   logic             write_accept;
   logic             full_next;
   logic             almost_next;
   logic             overflow_next;

   sync_2ff #(
      .width(ptr_w)
   ) u_read_ptr_sync (
      .clk (write_clock_i),
      .rst (write_reset_i),
      .din (read_to_write_pointer_i),
      .dout(rq2)
   );

   assign write_address_o = wbin[addr_size-1:0];

   always_comb begin
      write_accept  = write_inc_i & ~write_full_o;
      wbin_next     = wbin + ptr_w'(write_accept);
      wgray_next    = ptr_w'(bin2gray(ptr_w_max'(wbin_next)));
      rbin_sync     = ptr_w'(gray2bin(ptr_w_max'(rq2)));
      level_next    = wbin_next - rbin_sync;
      // Full when the pointers are one lap apart: top two Gray bits inverted, rest equal
      full_next     = (wgray_next == {~rq2[addr_size:addr_size-1], rq2[addr_size-2:0]});
      almost_next   = (level_next >= almost_threshold) | full_next;
      // Set dominates clear so a dropped write is never lost
      overflow_next = (write_inc_i & write_full_o) |
                      (write_overflow_o & ~write_overflow_clear_i);
   end

   always_ff @(posedge write_clock_i or posedge write_reset_i) begin
      if (write_reset_i) begin
         wbin                <= '0;
         write_pointer_o     <= '0;
         write_full_o        <= 1'b0;
         write_almost_full_o <= 1'b0;
         write_level_o       <= '0;
         write_overflow_o    <= 1'b0;
      end else begin
         wbin                <= wbin_next;
         write_pointer_o     <= wgray_next;
         write_full_o        <= full_next;
         write_almost_full_o <= almost_next;
         write_level_o       <= level_next;
         write_overflow_o    <= overflow_next;
      end
   end

endmodule

// File: tb/tb_write_full_block.sv
// Scoreboard bench for write_full_block: count-based reference model feeds a queue,
// an independent monitor compares each post-edge DUT state against it.
module tb_write_full_block;

   logic       clk = 1'b0;
   logic       rst;
   logic       inc;
   logic       clr;
   logic [4:0] rptr;
   logic [3:0] addr;
   logic [4:0] wptr;
   logic       full;
   logic       afull;
   logic [4:0] level;
   logic       ovf;

   always #5 clk = ~clk;

   write_full_block #(
      .addr_size      (4),
      .almost_full_gap(2)
   ) dut (
      .write_clock_i          (clk),
      .write_reset_i          (rst),
      .write_inc_i            (inc),
      .read_to_write_pointer_i(rptr),
      .write_overflow_clear_i (clr),
      .write_address_o        (addr),
      .write_pointer_o        (wptr),
      .write_full_o           (full),
      .write_almost_full_o    (afull),
      .write_level_o          (level),
      .write_overflow_o       (ovf)
   );

   typedef struct {
      int addr;
      int ptr;
      int full;
      int afull;
      int level;
      int ovf;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference state in plain counts: writes accepted, reads done, reads as seen after sync delay
   int wr_total = 0;
   int rd_total = 0;
   int seen1    = 0;
   int seen2    = 0;
   bit m_full   = 1'b0;
   bit m_ovf    = 1'b0;

   function automatic int to_gray(input int n);
      int b;
      b = n & 31;
      return (b ^ (b >> 1)) & 31;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Expected outputs after the coming clock edge, given inputs now on the pins
   task automatic model_edge();
      exp_t e;
      int   lev;
      bit   acc;
      if (rst) begin
         wr_total = 0;
         seen1    = 0;
         seen2    = 0;
         m_full   = 1'b0;
         m_ovf    = 1'b0;
         e = '{addr: 0, ptr: 0, full: 0, afull: 0, level: 0, ovf: 0};
      end else begin
         acc      = inc && !m_full;
         m_ovf    = (inc && m_full) || (m_ovf && !clr);
         wr_total = wr_total + (acc ? 1 : 0);
         lev      = (wr_total - seen2) & 31;
         m_full   = (lev == 16);
         e.addr   = wr_total % 16;
         e.ptr    = to_gray(wr_total);
         e.full   = m_full ? 1 : 0;
         e.afull  = (lev >= 14) ? 1 : 0;
         e.level  = lev;
         e.ovf    = m_ovf ? 1 : 0;
         seen2    = seen1;
         seen1    = rd_total;
      end
      q.push_back(e);
   endtask

   task automatic step(input bit i_inc, input bit i_clr, input bit i_rst);
      @(negedge clk);
      rst  = i_rst;
      inc  = i_inc;
      clr  = i_clr;
      rptr = 5'(to_gray(rd_total));
      model_edge();
   endtask

   task automatic async_reset_check();
      @(negedge clk);
      inc  = 1'b0;
      clr  = 1'b0;
      rst  = 1'b1;
      #1;
      chk("async_rst_addr", int'(addr), 0);
      chk("async_rst_ptr", int'(wptr), 0);
      chk("async_rst_full", int'(full), 0);
      chk("async_rst_afull", int'(afull), 0);
      chk("async_rst_level", int'(level), 0);
      chk("async_rst_ovf", int'(ovf), 0);
      model_edge();
   endtask

   // Monitor: one transaction per clock edge with an expectation pending
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            $display("txn t=%0t addr=%0d ptr=%b level=%0d full=%0b afull=%0b ovf=%0b",
                     $time, addr, wptr, level, full, afull, ovf);
            chk("addr", int'(addr), e.addr);
            chk("ptr", int'(wptr), e.ptr);
            chk("full", int'(full), e.full);
            chk("afull", int'(afull), e.afull);
            chk("level", int'(level), e.level);
            chk("ovf", int'(ovf), e.ovf);
         end
      end
   end

   initial begin
      int wait_cycles;
      rst  = 1'b1;
      inc  = 1'b0;
      clr  = 1'b0;
      rptr = 5'd0;
      #1;
      chk("reset_level", int'(level), 0);
      chk("reset_full", int'(full), 0);
      step(0, 0, 1);
      step(0, 0, 1);

      // Fill to full with the read pointer parked at 0
      for (int i = 0; i < 16; i++) step(1, 0, 0);
      step(0, 0, 0);

      // Writes while full are dropped and set the sticky flag; clear, then clear racing a drop
      for (int i = 0; i < 3; i++) step(1, 0, 0);
      step(0, 0, 0);
      step(0, 1, 0);
      step(0, 0, 0);
      step(1, 1, 0);
      step(0, 0, 0);

      // One read: full releases three edges later, then one write refills
      rd_total = 1;
      for (int i = 0; i < 4; i++) step(0, 0, 0);
      step(1, 0, 0);
      step(0, 1, 0);

      // Drain to level 4, then stream 40 writes with reads trailing, across the pointer wrap
      rd_total = wr_total - 4;
      for (int i = 0; i < 3; i++) step(0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         rd_total = wr_total - 1;
         step(1, 0, 0);
      end
      rd_total = wr_total;
      for (int i = 0; i < 3; i++) step(0, 0, 0);

      // Random traffic: reads never overtake accepted writes
      for (int i = 0; i < 300; i++) begin
         if (rd_total < wr_total && $urandom_range(0, 1) == 1) rd_total++;
         step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 0);
      end

      // Mid-burst reset at level 9, then the first write after release
      rd_total = 0;
      step(0, 0, 1);
      for (int i = 0; i < 9; i++) step(1, 0, 0);
      async_reset_check();
      step(0, 0, 1);
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);

      wait_cycles = 0;
      while (q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      #2;
      chk("scoreboard_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/write_full_block.md
WRITE_FULL_BLOCK -- requirements
Module: write_full_block

Interface
REQ-001 SHALL have parameter addr_size, default 4, address width; FIFO depth = 2^addr_size; legal range 2..8.
REQ-002 SHALL have parameter almost_full_gap, default 2, free slots at or below which almost-full asserts; legal range 1..(2^addr_size - 1).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 write_clock_i  input  1  clock, write domain.
REQ-005 write_reset_i  input  1  asynchronous active-high reset, write domain.
REQ-006 write_inc_i  input  1  write request; advances the write address when not full.
REQ-007 read_to_write_pointer_i  input  addr_size+1  Gray read pointer from the read domain; asynchronous to write_clock_i.
REQ-008 write_overflow_clear_i  input  1  clears the sticky overflow flag.
REQ-009 write_address_o  output  addr_size  binary write address to the memory.
REQ-010 write_pointer_o  output  addr_size+1  registered Gray write pointer, to the read domain.
REQ-011 write_full_o  output  1  FIFO full.
REQ-012 write_almost_full_o  output  1  free slots <= almost_full_gap.
REQ-013 write_level_o  output  addr_size+1  occupied entries as seen by the write domain, 0..2^addr_size.
REQ-014 write_overflow_o  output  1  sticky: a write was attempted while full.

Function
REQ-015 Internal binary pointer wbin (addr_size+1 bits); wbin_next = wbin + (write_inc_i & ~write_full_o), wrapping modulo 2^(addr_size+1).
REQ-016 write_address_o SHALL equal wbin[addr_size-1:0] combinationally.
REQ-017 wgray_next = (wbin_next >> 1) ^ wbin_next; wbin and write_pointer_o SHALL register wbin_next and wgray_next each clock.
REQ-018 read_to_write_pointer_i SHALL pass through a two-flop synchronizer (rq1, rq2) before any use.
REQ-019 rbin_sync SHALL be the Gray-to-binary conversion of rq2 (bit i = XOR of rq2[addr_size:i]).
REQ-020 level_next = (wbin_next - rbin_sync) modulo 2^(addr_size+1); write_level_o SHALL register level_next.
REQ-021 write_full_o SHALL register (wgray_next == {~rq2[addr_size:addr_size-1], rq2[addr_size-2:0]}).
REQ-022 write_almost_full_o SHALL register (level_next >= 2^addr_size - almost_full_gap); it SHALL be 1 whenever write_full_o is 1.
REQ-023 A write_inc_i while write_full_o = 1 SHALL be dropped: wbin unchanged, no memory address advance.
REQ-024 A dropped write SHALL set write_overflow_o on the next edge; it holds until write_overflow_clear_i = 1. Set wins when set and clear occur in the same cycle.
REQ-025 Latency: a write changes write_pointer_o, write_level_o and the flags one edge later. A read pointer change reaches the flags no earlier than 3 write edges after it is stable at the input.
REQ-026 Pointer wrap: wraparound from 2^(addr_size+1)-1 to 0 SHALL keep the full and level results correct; MSB-differs/rest-equal means full, not empty.
REQ-027 Full SHALL be conservative: it may deassert late after a read, but it SHALL never deassert early.

Reset
REQ-028 While write_reset_i = 1 the following SHALL be 0: wbin, write_pointer_o, rq1, rq2, write_full_o, write_almost_full_o, write_level_o and write_overflow_o; write_address_o is then 0.
REQ-029 Assertion of reset mid-operation SHALL take effect immediately and asynchronously. Release SHALL be synchronous to write_clock_i. The first write is accepted on the first edge after release.

Structure
REQ-030 Package i2c_fifo_pkg SHALL hold the default addr_size, the depth derivation, and the binary-to-Gray and Gray-to-binary functions, shared with the read-side empty logic.
REQ-031 The two-flop synchronizer SHALL be sub-module sync_2ff, parameterized by width and reused for the write-to-read direction.
REQ-032 No memory array in this block; the memory is external.

Verification (addr_size=4, almost_full_gap=2, depth 16)
REQ-033 Reset, then 16 writes with the read pointer held at 0.
  - write_level_o counts 1..16.
  - write_almost_full_o rises after write 14.
  - write_full_o rises after write 16.
  - write_pointer_o = 5'b11000.
REQ-034 From full, write_inc_i = 1 for 3 cycles.
  - wbin stays 16.
  - write_overflow_o = 1 and holds.
  - Asserting clear for 1 cycle drops it to 0.
  - Clear plus a dropped write in the same cycle keeps it at 1.
REQ-035 From full, move the read pointer Gray 0 -> 1.
  - write_full_o falls exactly 3 edges later.
  - write_level_o = 15.
  - The next write refills to full.
REQ-036 Run 40 writes with the read side trailing by 4, crossing the 31->0 wrap.
  - write_level_o stays 4.
  - write_full_o is never 1.
REQ-037 Assert write_reset_i mid-burst at level 9.
  - All outputs go to 0 immediately, before the next edge.
  - After release, the first write gives write_address_o = 1 on the next cycle.
